// File: rtl/mfp_ahb_7sd_scan_if.sv
// AHB-Lite slave-side bus bundle for the 7-segment scan peripheral.
// master: drives address/control/write data, samples HRDATA.
// slave : samples address/control/write data, drives registered HRDATA.
interface mfp_ahb_7sd_scan_if;
  logic [3:0]  HADDR;   // word index (byte address bits [5:2])
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HRDATA;

  modport master (output HADDR, HTRANS, HWDATA, HWRITE, HSEL, input HRDATA);
  modport slave  (input HADDR, HTRANS, HWDATA, HWRITE, HSEL, output HRDATA);
endinterface

// File: rtl/mfp_ahb_7sd_scan.sv
// AHB-Lite 7-segment peripheral with built-in scan multiplexer.
// Registers: CTRL(0) DIGEN(1) DP(2) BLINK(3) DATA0..3(4..7) STATUS(8, ro).
// Ports:
//   HCLK, HRESETn      clock, synchronous active-low reset
//   bus (slave)        AHB-Lite address/data signals, registered HRDATA
//   OUT_7SD_ANODE      per-digit enables, active-low
//   OUT_7SD_CATHODE    {DP,CA..CG}, active-low
// Optional: define MFP_7SD_BLINK_EN to build the BLINK register and the
// frame-driven blink phase; otherwise BLINK reads 0 and nothing blinks.
module mfp_ahb_7sd_scan #(
  parameter int N_DIG        = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  mfp_ahb_7sd_scan_if.slave    bus,
  output logic [N_DIG-1:0]     OUT_7SD_ANODE,
  output logic [7:0]           OUT_7SD_CATHODE
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // address-phase capture
  logic [3:0] haddr_q;
  logic [1:0] htrans_q;
  logic       hwrite_q, hsel_q, we;

  logic                  raw, blank;
  logic [7:0]            bright;
  logic [N_DIG-1:0]      digen, dp, blink;
  logic [N_DIG-1:0][7:0] data;

  logic [PW-1:0] presc;
  logic [3:0]    idx;
  logic [15:0]   frame;
  logic [7:0]    pwm;
  logic          blink_phase, slot_end, frame_end;

  assign we        = hsel_q & hwrite_q & (htrans_q != 2'b00);
  assign slot_end  = (presc == PW'(SCAN_DIV - 1));
  assign frame_end = slot_end & (idx == 4'(N_DIG - 1));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      haddr_q <= '0; htrans_q <= '0; hwrite_q <= 1'b0; hsel_q <= 1'b0;
      raw <= 1'b0; blank <= 1'b0; bright <= 8'hFF;
      digen <= '0; dp <= '0;
    end else begin
      haddr_q <= bus.HADDR; htrans_q <= bus.HTRANS;
      hwrite_q <= bus.HWRITE; hsel_q <= bus.HSEL;
      if (we) begin
        case (haddr_q)
          4'd0: begin
            raw    <= bus.HWDATA[0];
            blank  <= bus.HWDATA[1];
            bright <= bus.HWDATA[15:8];
          end
          4'd1: digen <= bus.HWDATA[N_DIG-1:0];
          4'd2: dp    <= bus.HWDATA[N_DIG-1:0];
          default: ;
        endcase
      end
    end
  end

  // digit d lives in byte d%4 of DATA word d/4
  always_ff @(posedge HCLK) begin
    if (!HRESETn) data <= '0;
    else
      for (int d = 0; d < N_DIG; d++)
        if (we && haddr_q == 4'(4 + d / 4)) data[d] <= bus.HWDATA[8*(d%4) +: 8];
  end

  // scan timing: prescaler -> digit index -> frame counter; pwm free-runs
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      presc <= '0; idx <= '0; frame <= '0; pwm <= '0;
    end else begin
      pwm   <= pwm + 8'd1;
      presc <= slot_end ? '0 : presc + PW'(1);
      if (slot_end) idx <= frame_end ? 4'd0 : idx + 4'd1;
      if (frame_end) frame <= frame + 16'd1;
    end
  end

`ifdef MFP_7SD_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] bcnt;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      blink <= '0; bcnt <= '0; blink_phase <= 1'b0;
    end else begin
      if (we && haddr_q == 4'd3) blink <= bus.HWDATA[N_DIG-1:0];
      if (frame_end) begin
        if (bcnt == BW'(BLINK_FRAMES - 1)) begin
          bcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end
    end
  end
`else
  assign blink       = '0;
  assign blink_phase = 1'b0;
`endif

  // read mux on the undelayed address; HRDATA is its registered copy
  logic [31:0] rdata_nx;
  always_comb begin
    rdata_nx = '0;
    case (bus.HADDR)
      4'd0: rdata_nx = {16'h0, bright, 6'h0, blank, raw};
      4'd1: rdata_nx[N_DIG-1:0] = digen;
      4'd2: rdata_nx[N_DIG-1:0] = dp;
      4'd3: rdata_nx[N_DIG-1:0] = blink;
      4'd8: rdata_nx = {frame, 7'h0, blink_phase, 4'h0, idx};
      default: ;
    endcase
    for (int d = 0; d < N_DIG; d++)
      if (bus.HADDR == 4'(4 + d / 4)) rdata_nx[8*(d%4) +: 8] = data[d];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) bus.HRDATA <= '0;
    else          bus.HRDATA <= rdata_nx;
  end

  // {CA..CG}, active-high
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h7E; 4'h1: hex7 = 7'h30; 4'h2: hex7 = 7'h6D; 4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33; 4'h5: hex7 = 7'h5B; 4'h6: hex7 = 7'h5F; 4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h7B; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E; 4'hD: hex7 = 7'h3D; 4'hE: hex7 = 7'h4F; default: hex7 = 7'h47;
    endcase
  endfunction

  logic [N_DIG-1:0] lit;
  logic [6:0]       cur, seg;
  logic             cur_dp;

  always_comb begin
    lit    = '0;
    cur    = '0;
    cur_dp = 1'b0;
    for (int d = 0; d < N_DIG; d++) begin
      lit[d] = (idx == 4'(d)) & digen[d] & ~blank & ~(blink[d] & blink_phase) & (pwm <= bright);
      if (idx == 4'(d)) begin
        cur    = data[d][6:0];
        cur_dp = dp[d];
      end
    end
    seg = raw ? cur : hex7(cur[3:0]);
  end

  // anode and cathode are registered together; an unlit slot blanks both
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      OUT_7SD_ANODE   <= '1;
      OUT_7SD_CATHODE <= 8'hFF;
    end else begin
      OUT_7SD_ANODE   <= ~lit;
      OUT_7SD_CATHODE <= (|lit) ? ~{cur_dp, seg} : 8'hFF;
    end
  end
endmodule

// File: doc/mfp_ahb_7sd_scan.md
Name: mfp_ahb_7sd_scan

Overview:
- Parametrised AHB-Lite 7-segment peripheral for 1..16 digits, with the scan-multiplex driver built in.
- Adds hex or raw segment modes, global PWM brightness, per-digit blink and a read-only scan status register.
- Sits on the AHB slave mux beside the GPIO peripherals and drives the board anode/cathode pins directly.

Parameters:
- N_DIG, 8, number of digits (1..16).
- SCAN_DIV, 50000, HCLK cycles per digit slot (>=2).
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, synchronous, active-low.
- HADDR  in  4  word index (byte address bits [5:2]).
- HTRANS  in  2  AHB transfer type.
- HWDATA  in  32  write data (data phase).
- HWRITE  in  1  write strobe (address phase).
- HSEL  in  1  slave select (address phase).
- HRDATA  out  32  registered read data.
- OUT_7SD_ANODE  out  N_DIG  digit enables, active-low.
- OUT_7SD_CATHODE  out  8  {DP,CA,CB,CC,CD,CE,CF,CG}, active-low.

Behaviour:
- One clock (HCLK). Reset is synchronous, active-low on HRESETn, sampled at the HCLK posedge.
- Reset values:
  - CTRL=0x0000FF00: RAW=0, BLANK=0, BRIGHT=0xFF.
  - DIGEN, DP, BLINK and DATA0..3 = 0.
  - HRDATA=0; ANODE all 1; CATHODE 0xFF.
  - Scan index, prescaler, PWM counter, frame counter and blink_phase = 0.
- Register map (HADDR):
  - 0 CTRL: bit0 RAW, bit1 BLANK, bits[15:8] BRIGHT.
  - 1 DIGEN.
  - 2 DP.
  - 3 BLINK.
  - 4..7 DATA0..3: digit 4k+j in byte j of DATAk.
  - 8 STATUS (read-only): [3:0] scan index, [8] blink_phase, [31:16] frame count.
  - Other addresses read 0; writes to them are ignored.
  - Bits at or above N_DIG, and DATA words for digits >= N_DIG, read 0 and ignore writes.
- Writes: HADDR, HWRITE, HSEL and HTRANS are registered in the address phase. The write commits at the end of the data-phase cycle when the delayed HTRANS!=IDLE and HSEL and HWRITE are all true.
- Reads: HRDATA updates every cycle from the undelayed HADDR, one-cycle registered. This happens regardless of HSEL.
- Write then read of the same register in back-to-back transfers returns the old value. This is documented, not hazard-fixed.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap the index advances 0..N_DIG-1.
  - When the index wraps from N_DIG-1 to 0, the frame counter increments (16-bit, wraps).
  - Every BLINK_FRAMES frames, blink_phase toggles.
- Digit d is lit when all of the following hold:
  - index==d;
  - DIGEN[d]=1;
  - BLANK=0;
  - not (BLINK[d] & blink_phase);
  - pwm_cnt <= BRIGHT, where pwm_cnt is an 8-bit free-running counter incremented every cycle.
- BRIGHT=0xFF gives always-on; BRIGHT=0 gives a 1/256 duty.
- Segment source:
  - RAW=0: byte[3:0] is hex-decoded, standard 0-F glyphs (e.g. 0 -> CA..CF on, CG off).
  - RAW=1: byte[6:0] = {CA..CG}, active-high.
  - DP segment = DP[d].
- Output inversion: outputs are registered (1 cycle after the internal state). Cathodes are inverted to active-low.
- Unlit digit: its anode is 1 and CATHODE=0xFF, so there is no ghosting.
- At most one anode is 0 in any cycle. Anode and cathode change in the same cycle.
- A register write coinciding with a slot advance takes effect in the next output update.
- Reset mid-scan: all outputs go to their reset values on the next edge, and scanning restarts at digit 0.

Optional Feature:
- MFP_7SD_BLINK_EN defined: BLINK register, blink_phase and frame-driven toggling are present as specified.
- Undefined: BLINK reads 0 and writes are ignored; blink_phase is held at 0 and STATUS[8]=0. No digit ever blinks.

Test Plan:
1. Reset (HRESETn=0 for 2 cycles) -> ANODE=0xFF, CATHODE=0xFF, HRDATA=0, STATUS reads 0. Reading CTRL returns 0x0000FF00.
2. N_DIG=8, SCAN_DIV=4. Write DIGEN=0xFF, DATA0=0x03020100, DATA1=0x07060504 -> ANODE steps through 0xFE,0xFD,...,0x7F, 4 cycles each. Digit 0 CATHODE=0x81, digit 1 CATHODE=0xCF.
3. RAW=1, DATA0 byte0=0x7F, DP=0x01 -> digit 0 CATHODE=0x00. Then write BLANK=1 -> ANODE=0xFF from the next output update onward.
4. BRIGHT=0x3F with a digit enabled -> within its slot the anode is low for exactly 64 of every 256 cycles, aligned to pwm_cnt 0..63 (use SCAN_DIV=1024).
5. With MFP_7SD_BLINK_EN, BLINK_FRAMES=2, BLINK=0x02 -> digit 1 is dark during alternating 2-frame windows while digit 0 is unaffected. STATUS[8] toggles every 2 frames.
6. Write HTRANS=IDLE with HSEL=1, plus writes to address 9 and to DATA3 when N_DIG=8 -> no register changes; all read back 0 where specified.
